// File: rtl/sd_sector_loader.sv
// sd_sector_loader
// Drives an sd_controller through a run of consecutive 512-byte block reads
// and streams each received byte into a byte-wide memory write port.
// Memory back-pressure throttles the controller by holding rd low while a
// byte is waiting to be written. A controller timeout, seen as ready rising
// mid-block, restarts the same sector. After a bounded number of attempts
// the loader reports an error.
module sd_sector_loader #(
  parameter int MEM_AW       = 18,
  parameter bit BLOCK_ADDR   = 1'b1,
  parameter int MAX_RETRY    = 3,
  parameter int INIT_TIMEOUT = 2**26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       start_sector,
  input  logic [15:0]       sector_count,
  input  logic [MEM_AW-1:0] mem_base,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       sectors_done,
  output logic              sd_rd,
  output logic [31:0]       sd_address,
  input  logic              sd_ready,
  input  logic              sd_byte_available,
  input  logic [7:0]        sd_dout,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  input  logic              mem_ready
);

  localparam int WD_W = $clog2(INIT_TIMEOUT + 1);
  localparam int RT_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_READY = 3'd1,
    S_ISSUE      = 3'd2,
    S_READ       = 3'd3,
    S_DRAIN      = 3'd4,
    S_WAIT_IDLE  = 3'd5,
    S_DONE       = 3'd6,
    S_ERROR      = 3'd7
  } state_t;

  // Translate a sector number into the controller's address space.
  function automatic logic [31:0] sector_to_addr(input logic [31:0] sector);
    logic [31:0] a;
    if (BLOCK_ADDR) begin
      a = sector;
    end else begin
      a = {sector[22:0], 9'd0};
    end
    return a;
  endfunction

  // Compute the memory byte address of byte idx within sector offset sec. The
  // result wraps modulo 2^MEM_AW.
  function automatic logic [MEM_AW-1:0] byte_addr(input logic [MEM_AW-1:0] base,
                                                  input logic [15:0]       sec,
                                                  input logic [9:0]        idx);
    return base + MEM_AW'({sec, 9'd0}) + MEM_AW'(idx);
  endfunction

  state_t            state_q, state_d;
  logic [31:0]       cur_sector_q, cur_sector_d;
  logic [15:0]       count_q, count_d;
  logic [MEM_AW-1:0] base_q, base_d;
  logic [15:0]       sectors_done_q, sectors_done_d;
  logic [RT_W-1:0]   retry_q, retry_d;
  logic [9:0]        idx_q, idx_d;
  logic              pending_q, pending_d;
  logic              bavail_q, bavail_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic [31:0]       sd_address_q, sd_address_d;
  logic              error_q, error_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              sd_rd_q, sd_rd_d;
  logic              mem_we_q, mem_we_d;
  logic              rise_s;

  assign rise_s = sd_byte_available & ~bavail_q;

  // Next-state logic plus next values for every register and output.
  always_comb begin
    state_d        = state_q;
    cur_sector_d   = cur_sector_q;
    count_d        = count_q;
    base_d         = base_q;
    sectors_done_d = sectors_done_q;
    retry_d        = retry_q;
    idx_d          = idx_q;
    pending_d      = pending_q;
    bavail_d       = sd_byte_available;
    wd_d           = wd_q;
    mem_addr_d     = mem_addr_q;
    mem_data_d     = mem_data_q;
    error_d        = error_q;

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          cur_sector_d   = start_sector;
          count_d        = sector_count;
          base_d         = mem_base;
          sectors_done_d = 16'd0;
          retry_d        = '0;
          error_d        = 1'b0;
          wd_d           = '0;
          pending_d      = 1'b0;
          if (sector_count == 16'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT_READY;
          end
        end else begin
          state_d = state_q;
        end
      end

      S_WAIT_READY: begin
        if (sd_ready) begin
          state_d = S_ISSUE;
        end else if (wd_q == WD_W'(INIT_TIMEOUT - 1)) begin
          state_d = S_ERROR;
          error_d = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      S_ISSUE: begin
        if (!sd_ready) begin
          state_d   = S_READ;
          idx_d     = 10'd0;
          pending_d = 1'b0;
        end else begin
          state_d = S_ISSUE;
        end
      end

      S_READ: begin
        if (sd_ready) begin
          // The controller gave up on this block. Drop the half-written
          // sector and try it again from its first byte.
          pending_d = 1'b0;
          retry_d   = retry_q + RT_W'(1);
          if (retry_d == RT_W'(MAX_RETRY)) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else begin
            state_d = S_WAIT_READY;
            wd_d    = '0;
          end
        end else if (mem_we_q && mem_ready) begin
          pending_d = 1'b0;
          if (idx_q == 10'd511) begin
            idx_d   = 10'd512;
            state_d = S_DRAIN;
          end else begin
            idx_d = idx_q + 10'd1;
          end
        end else if (rise_s && !pending_q) begin
          mem_data_d = sd_dout;
          mem_addr_d = byte_addr(base_q, sectors_done_q, idx_q);
          pending_d  = 1'b1;
        end else begin
          pending_d = pending_q;
        end
      end

      S_DRAIN: begin
        if (!sd_byte_available) begin
          state_d = S_WAIT_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end

      S_WAIT_IDLE: begin
        if (sd_ready) begin
          sectors_done_d = sectors_done_q + 16'd1;
          retry_d        = '0;
          cur_sector_d   = cur_sector_q + 32'd1;
          if (sectors_done_d == count_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_WAIT_IDLE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered output values, decoded from the state being entered.
  always_comb begin
    busy_d       = (state_d != S_IDLE) && (state_d != S_ERROR);
    done_d       = (state_d == S_DONE);
    sd_rd_d      = (state_d == S_ISSUE) || (state_d == S_DRAIN) ||
                   ((state_d == S_READ) && !pending_d);
    mem_we_d     = (state_d == S_READ) && pending_d;
    sd_address_d = (state_d == S_ISSUE) ? sector_to_addr(cur_sector_d) : sd_address_q;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cur_sector_q   <= 32'd0;
      count_q        <= 16'd0;
      base_q         <= '0;
      sectors_done_q <= 16'd0;
      retry_q        <= '0;
      idx_q          <= 10'd0;
      pending_q      <= 1'b0;
      bavail_q       <= 1'b0;
      wd_q           <= '0;
      mem_addr_q     <= '0;
      mem_data_q     <= 8'd0;
      sd_address_q   <= 32'd0;
      error_q        <= 1'b0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
      sd_rd_q        <= 1'b0;
      mem_we_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_sector_q   <= cur_sector_d;
      count_q        <= count_d;
      base_q         <= base_d;
      sectors_done_q <= sectors_done_d;
      retry_q        <= retry_d;
      idx_q          <= idx_d;
      pending_q      <= pending_d;
      bavail_q       <= bavail_d;
      wd_q           <= wd_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_q     <= mem_data_d;
      sd_address_q   <= sd_address_d;
      error_q        <= error_d;
      done_q         <= done_d;
      busy_q         <= busy_d;
      sd_rd_q        <= sd_rd_d;
      mem_we_q       <= mem_we_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign sectors_done = sectors_done_q;
  assign sd_rd        = sd_rd_q;
  assign sd_address   = sd_address_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data     = mem_data_q;
  assign mem_we       = mem_we_q;

endmodule

// File: tb/tb_sd_sector_loader.sv
// Bench for sd_sector_loader: behavioural sd_controller card model, memory
// sink with selectable back-pressure, and a write scoreboard.
`timescale 1ns/1ps
module tb_sd_sector_loader;

  localparam int AW = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start;
  logic [31:0]   start_sector;
  logic [15:0]   sector_count;
  logic [AW-1:0] mem_base;
  logic          busy, done, error;
  logic [15:0]   sectors_done;
  logic          sd_rd;
  logic [31:0]   sd_address;
  logic          sd_ready, sd_byte_available;
  logic [7:0]    sd_dout;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          mem_we;
  logic          mem_ready;

  // Byte-addressing instance, used only to check the address translation.
  logic          b_start;
  logic          b_busy, b_done, b_error;
  logic [15:0]   b_sectors_done;
  logic          b_sd_rd;
  logic [31:0]   b_sd_address;
  logic [AW-1:0] b_mem_addr;
  logic [7:0]    b_mem_data;
  logic          b_mem_we;

  sd_sector_loader #(.MEM_AW(AW), .BLOCK_ADDR(1'b1), .MAX_RETRY(3), .INIT_TIMEOUT(1000)) u_dut (
    .clk(clk), .reset(reset), .start(start), .start_sector(start_sector),
    .sector_count(sector_count), .mem_base(mem_base), .busy(busy), .done(done),
    .error(error), .sectors_done(sectors_done), .sd_rd(sd_rd), .sd_address(sd_address),
    .sd_ready(sd_ready), .sd_byte_available(sd_byte_available), .sd_dout(sd_dout),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_ready(mem_ready)
  );

  sd_sector_loader #(.MEM_AW(AW), .BLOCK_ADDR(1'b0), .MAX_RETRY(3), .INIT_TIMEOUT(1000)) u_dut_b (
    .clk(clk), .reset(reset), .start(b_start), .start_sector(start_sector),
    .sector_count(sector_count), .mem_base(mem_base), .busy(b_busy), .done(b_done),
    .error(b_error), .sectors_done(b_sectors_done), .sd_rd(b_sd_rd), .sd_address(b_sd_address),
    .sd_ready(1'b1), .sd_byte_available(1'b0), .sd_dout(8'h00),
    .mem_addr(b_mem_addr), .mem_data(b_mem_data), .mem_we(b_mem_we), .mem_ready(1'b1)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  int  n_cmp = 0;
  int  n_bad = 0;
  wr_t sb[$];
  int  wr_cnt = 0;
  int  done_cnt = 0;
  int  rd_cnt = 0;
  int  mem_mode = 0;
  int  mcyc = 0;

  // Card model state.
  localparam int C_INIT = 0, C_IDLE = 1, C_LAT = 2, C_WRD = 3, C_LOW = 4, C_CRC = 5, C_FAIL = 6;
  int          c_st = C_INIT;
  int          c_cnt = 0;
  int          c_idx = 0;
  logic [31:0] c_addr = 32'd0;
  logic [31:0] rd_addr_log[$];
  int          fail_left = 0;
  bit          salt_en = 1'b0;
  logic        rd_at_return = 1'b0;

  // One negedge step of the sd_controller model.
  task automatic card_step();
    if (reset) begin
      sd_ready = 1'b0; sd_byte_available = 1'b0; sd_dout = 8'h00;
      c_st = C_INIT; c_cnt = 0;
    end else begin
      case (c_st)
        C_INIT: begin
          c_cnt++;
          if (c_cnt >= 4) begin sd_ready = 1'b1; c_st = C_IDLE; end
        end
        C_IDLE: begin
          if (sd_ready && sd_rd) begin
            sd_ready = 1'b0;
            c_addr = sd_address;
            rd_addr_log.push_back(sd_address);
            c_cnt = 0;
            if (fail_left > 0) begin fail_left--; c_st = C_FAIL; end
            else c_st = C_LAT;
          end
        end
        C_LAT: begin
          c_cnt++;
          if (c_cnt >= 3) begin c_idx = 0; c_st = C_WRD; end
        end
        C_WRD: begin
          if (sd_rd) begin
            if (c_idx == 512) begin
              c_cnt = 0; c_st = C_CRC;
            end else begin
              sd_byte_available = 1'b1;
              sd_dout = 8'(c_idx) + (salt_en ? c_addr[7:0] * 8'd17 : 8'd0);
              c_st = C_LOW;
            end
          end
        end
        C_LOW: begin
          sd_byte_available = 1'b0; c_idx++; c_st = C_WRD;
        end
        C_CRC: begin
          c_cnt++;
          if (c_cnt >= 4) begin rd_at_return = sd_rd; sd_ready = 1'b1; c_st = C_IDLE; end
        end
        C_FAIL: begin
          c_cnt++;
          if (c_cnt >= 6) begin sd_ready = 1'b1; c_st = C_IDLE; end
        end
        default: c_st = C_INIT;
      endcase
    end
  endtask

  initial begin
    sd_ready = 1'b0; sd_byte_available = 1'b0; sd_dout = 8'h00;
    forever begin
      @(negedge clk);
      card_step();
    end
  end

  // Memory sink: drive mem_ready, and score every write the DUT will retire
  // on the coming posedge.
  initial begin
    mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        mem_ready = (mem_mode == 0) ? 1'b1 : ((mcyc % 4) == 0);
        mcyc++;
        if (done)  done_cnt++;
        if (sd_rd) rd_cnt++;
        if (mem_we && mem_ready) begin
          wr_t exp;
          wr_cnt++;
          n_cmp++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL write_extra: addr=%h data=%h but no write expected", mem_addr, mem_data);
          end else begin
            exp = sb.pop_front();
            if (mem_addr !== exp.a || mem_data !== exp.d) begin
              n_bad++;
              $display("FAIL write_data: got addr=%h data=%h, expected addr=%h data=%h",
                       mem_addr, mem_data, exp.a, exp.d);
            end
          end
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_not_busy(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      if (!busy) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic prep_job();
    sb.delete(); rd_addr_log.delete();
    wr_cnt = 0; done_cnt = 0; rd_cnt = 0;
  endtask

  task automatic test_reset();
    logic [78:0] outs;
    reset = 1'b1; start = 1'b0; b_start = 1'b0;
    start_sector = 32'd0; sector_count = 16'd0; mem_base = '0;
    repeat (3) @(negedge clk); #1;
    outs = {busy, done, error, sectors_done, sd_rd, sd_address, mem_addr, mem_data, mem_we};
    n_cmp++;
    if (outs !== 79'd0) begin n_bad++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk); #1;
    outs = {busy, done, error, sectors_done, sd_rd, sd_address, mem_addr, mem_data, mem_we};
    n_cmp++;
    if (outs !== 79'd0) begin n_bad++; $display("FAIL post_reset_idle: got %h expected 0", outs); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_single_sector();
    bit to;
    prep_job(); salt_en = 1'b0; mem_mode = 0; fail_left = 0;
    for (int i = 0; i < 512; i++) sb.push_back('{a: AW'(i), d: 8'(i)});
    start_sector = 32'd5; sector_count = 16'd1; mem_base = '0;
    pulse_start();
    wait_not_busy(20000, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL single_timeout: busy still 1, expected 0"); end
    n_cmp++;
    if (rd_addr_log.size() != 1) begin n_bad++; $display("FAIL single_reads: got %0d expected 1", rd_addr_log.size()); end
    else if (rd_addr_log[0] !== 32'd5) begin n_bad++; $display("FAIL single_sd_address: got %h expected 5", rd_addr_log[0]); end
    n_cmp++; if (wr_cnt != 512) begin n_bad++; $display("FAIL single_writes: got %0d expected 512", wr_cnt); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL single_done: got %0d expected 1", done_cnt); end
    n_cmp++; if (sectors_done !== 16'd1) begin n_bad++; $display("FAIL single_sectors_done: got %0d expected 1", sectors_done); end
    n_cmp++; if (rd_at_return !== 1'b0) begin n_bad++; $display("FAIL single_rd_before_ready: got %b expected 0", rd_at_return); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL single_error: got %b expected 0", error); end
  endtask

  task automatic test_backpressure_wrap();
    bit to;
    prep_job(); salt_en = 1'b1; mem_mode = 1; fail_left = 0;
    start_sector = 32'd100; sector_count = 16'd2; mem_base = 18'h3FF00;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 512; i++)
        sb.push_back('{a: mem_base + AW'(k * 512 + i), d: 8'(i) + 8'(100 + k) * 8'd17});
    pulse_start();
    wait_not_busy(40000, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL wrap_timeout: busy still 1, expected 0"); end
    n_cmp++; if (wr_cnt != 1024) begin n_bad++; $display("FAIL wrap_writes: got %0d expected 1024", wr_cnt); end
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL wrap_leftover: got %0d expected 0", sb.size()); end
    n_cmp++;
    if (rd_addr_log.size() != 2) begin n_bad++; $display("FAIL wrap_reads: got %0d expected 2", rd_addr_log.size()); end
    else if (rd_addr_log[1] !== 32'd101) begin n_bad++; $display("FAIL wrap_second_address: got %0d expected 101", rd_addr_log[1]); end
    n_cmp++; if (sectors_done !== 16'd2) begin n_bad++; $display("FAIL wrap_sectors_done: got %0d expected 2", sectors_done); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL wrap_done: got %0d expected 1", done_cnt); end
    mem_mode = 0;
  endtask

  task automatic test_byte_addressing();
    start_sector = 32'd3; sector_count = 16'd1;
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    repeat (4) @(negedge clk); #1;
    n_cmp++; if (b_sd_address !== 32'h600) begin n_bad++; $display("FAIL byteaddr_address: got %h expected 600", b_sd_address); end
    n_cmp++; if (b_sd_rd !== 1'b1) begin n_bad++; $display("FAIL byteaddr_rd: got %b expected 1", b_sd_rd); end
  endtask

  task automatic test_retry_once();
    bit to;
    prep_job(); salt_en = 1'b1; mem_mode = 0; fail_left = 1;
    start_sector = 32'd9; sector_count = 16'd1; mem_base = 18'h00100;
    for (int i = 0; i < 512; i++) sb.push_back('{a: 18'h00100 + AW'(i), d: 8'(i) + 8'd9 * 8'd17});
    pulse_start();
    wait_not_busy(20000, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL retry_timeout: busy still 1, expected 0"); end
    n_cmp++; if (rd_addr_log.size() != 2) begin n_bad++; $display("FAIL retry_reads: got %0d expected 2", rd_addr_log.size()); end
    n_cmp++; if (wr_cnt != 512) begin n_bad++; $display("FAIL retry_writes: got %0d expected 512", wr_cnt); end
    n_cmp++; if (done_cnt != 1 || error !== 1'b0) begin n_bad++; $display("FAIL retry_status: done=%0d error=%b expected 1/0", done_cnt, error); end
  endtask

  task automatic test_retry_exhaust();
    bit to;
    prep_job(); salt_en = 1'b0; fail_left = 100;
    start_sector = 32'd20; sector_count = 16'd1; mem_base = '0;
    pulse_start();
    wait_not_busy(3000, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL exhaust_timeout: busy still 1, expected 0"); end
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL exhaust_error: got %b expected 1", error); end
    n_cmp++; if (rd_addr_log.size() != 3) begin n_bad++; $display("FAIL exhaust_attempts: got %0d expected 3", rd_addr_log.size()); end
    n_cmp++; if (done_cnt != 0 || wr_cnt != 0) begin n_bad++; $display("FAIL exhaust_no_done: done=%0d writes=%0d expected 0/0", done_cnt, wr_cnt); end
    fail_left = 0;
    repeat (3) @(negedge clk);
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL exhaust_sticky: got %b expected 1", error); end
    sector_count = 16'd0;
    pulse_start(); #1;
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL exhaust_clear: got %b expected 0", error); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_zero_count();
    prep_job();
    sector_count = 16'd0; start_sector = 32'd7;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL zero_done_pulse: got %b expected 1", done); end
    @(negedge clk); #1;
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL zero_after: done=%b busy=%b expected 0/0", done, busy); end
    repeat (3) @(negedge clk);
    n_cmp++; if (rd_cnt != 0) begin n_bad++; $display("FAIL zero_rd: got %0d rd cycles expected 0", rd_cnt); end
  endtask

  task automatic test_reset_mid_job();
    bit to;
    logic [78:0] outs;
    prep_job(); salt_en = 1'b0; mem_mode = 0; fail_left = 0;
    for (int i = 0; i < 512; i++) sb.push_back('{a: AW'(i), d: 8'(i)});
    start_sector = 32'd1; sector_count = 16'd2; mem_base = '0;
    pulse_start();
    to = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk); #1;
      if (wr_cnt >= 100) begin to = 1'b0; break; end
    end
    n_cmp++; if (to) begin n_bad++; $display("FAIL midreset_reach100: writes=%0d expected >=100", wr_cnt); end
    #2 reset = 1'b1;
    #1;
    outs = {busy, done, error, sectors_done, sd_rd, sd_address, mem_addr, mem_data, mem_we};
    n_cmp++;
    if (outs !== 79'd0) begin n_bad++; $display("FAIL midreset_outputs: got %h expected 0", outs); end
    n_cmp++; if (b_sd_rd !== 1'b0 || b_busy !== 1'b0) begin n_bad++; $display("FAIL midreset_b: rd=%b busy=%b expected 0/0", b_sd_rd, b_busy); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    repeat (10) @(negedge clk); #1;
    n_cmp++; if (busy !== 1'b0 || sd_rd !== 1'b0) begin n_bad++; $display("FAIL midreset_idle: busy=%b rd=%b expected 0/0", busy, sd_rd); end
  endtask

  initial begin
    test_reset();
    test_single_sector();
    test_backpressure_wrap();
    test_byte_addressing();
    test_retry_once();
    test_retry_exhaust();
    test_zero_count();
    test_reset_mid_job();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sd_sector_loader.md
Name: sd_sector_loader

Overview:
- Sequences sd_controller to copy a run of consecutive 512-byte sectors from the microSD card into cartridge memory (ROM image loading at boot).
- Issues one block read per sector and throttles the controller through rd flow control when memory back-pressures.
- Detects controller read timeouts and retries, reporting done or error to the boot FSM.

Parameters:
MEM_AW, 18, memory byte-address width
BLOCK_ADDR, 1, 1: sd_address = sector number (SDHC); 0: sd_address = sector<<9 (byte addressing)
MAX_RETRY, 3, read attempts per sector before error
INIT_TIMEOUT, 2^26, clk cycles allowed waiting for sd_ready before error

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins job (ignored while busy)
start_sector  in  32  first sector number
sector_count  in  16  sectors to load
mem_base  in  MEM_AW  memory byte address of first byte
busy  out  1  job in progress
done  out  1  one-cycle pulse on successful completion
error  out  1  sticky until next accepted start
sectors_done  out  16  sectors fully written
sd_rd  out  1  to sd_controller rd
sd_address  out  32  to sd_controller address
sd_ready  in  1  from sd_controller ready
sd_byte_available  in  1  from sd_controller byte_available
sd_dout  in  8  from sd_controller dout
mem_addr  out  MEM_AW  write address
mem_data  out  8  write data
mem_we  out  1  write request, held until accepted
mem_ready  in  1  memory accepts when mem_we && mem_ready

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0.
- States: IDLE, WAIT_READY, ISSUE, READ, DRAIN, WAIT_IDLE, DONE, ERROR.
- IDLE, start=1:
  - Latch start_sector, sector_count, mem_base; clear error, sectors_done, retry count.
  - sector_count==0 -> DONE; otherwise -> WAIT_READY.
  - busy=1 in every state except IDLE and ERROR.
- WAIT_READY:
  - Watchdog counts clk cycles; sd_ready=1 -> ISSUE.
  - Watchdog reaching INIT_TIMEOUT -> ERROR.
- sd_address: registered from the current sector per BLOCK_ADDR; stable from ISSUE through WAIT_IDLE.
- ISSUE: sd_rd=1; sd_ready falls -> READ with byte index 0.
- READ:
  - sd_rd = !pending.
  - A rising edge of sd_byte_available (registered previous value) captures sd_dout into mem_data, sets mem_addr = mem_base + sector_offset*512 + index (mod 2^MEM_AW), and sets pending.
  - mem_we = pending.
  - mem_we && mem_ready clears pending and increments index.
  - Index reaching 512 with pending clear -> DRAIN.
  - While pending, the controller stalls in READ_BLOCK_DATA; no byte is lost.
- READ timeout: sd_ready=1 while index<512 means the controller timed out.
  - Discard any pending byte, increment retry count.
  - If retry count == MAX_RETRY -> ERROR; otherwise -> WAIT_READY, rewriting the same sector from its base.
- DRAIN: sd_rd=1 until sd_byte_available=0 (controller proceeds to CRC), then -> WAIT_IDLE.
- WAIT_IDLE:
  - sd_rd=0; wait for sd_ready=1.
  - On sd_ready=1: sectors_done++, retry count cleared, next sector.
  - sectors_done==sector_count -> DONE; otherwise -> ISSUE.
- DONE: done=1 for one cycle -> IDLE.
- ERROR: error=1, sd_rd=0, mem_we=0; start re-launches a job.
- sd_rd must never be high in IDLE, WAIT_READY, WAIT_IDLE, DONE or ERROR.
- Reset mid-job: immediate return to reset values. sd_controller is reset by the same net.
- start_sector+k wraps mod 2^32.

Test Plan:
- sector_count=1, start_sector=5, mem_base=0, BLOCK_ADDR=1, card model returns bytes i&0xFF, mem_ready=1 -> sd_address=5, 512 writes addr 0..511 with data 0..255,0..255; done pulse; sectors_done=1; sd_rd low before sd_ready returns.
- sector_count=2, mem_base=0x3FF00 (MEM_AW=18), mem_ready low 3 of every 4 cycles -> 1024 writes in order with no drops or duplicates; second sector sd_address=start+1; addresses wrap past 0x3FFFF to 0x00000.
- BLOCK_ADDR=0, start_sector=3 -> sd_address=0x600.
- Model times out once on sector 0 (no data token) -> one retry; writes restart at mem_base; final data correct; done pulse.
- Model times out on every attempt -> after 3 attempts error=1, busy=0, no done; next start clears error.
- sector_count=0 -> done one cycle after start, sd_rd never asserted. Reset asserted at byte 100 -> all outputs 0 immediately, state IDLE.
